// File: rtl/kairo_dbg_pkg.sv
// Shared debug-module definitions: DMI register map, abstract command fields,
// cmderr encoding and the abstract-register sequencer states.
package kairo_dbg_pkg;

  localparam logic [6:0] DMI_DATA0      = 7'h04;
  localparam logic [6:0] DMI_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DMI_COMMAND    = 7'h17;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  localparam int CMD_TYPE_LSB     = 24;
  localparam int CMD_AARSIZE_LSB  = 20;
  localparam int CMD_POSTEXEC_BIT = 18;
  localparam int CMD_TRANSFER_BIT = 17;
  localparam int CMD_WRITE_BIT    = 16;
  localparam int CMD_REGNO_LSB    = 0;

  localparam logic [2:0] AARSIZE_32 = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } dm_state_e;

  // progbufsize is 0 and datacount is 1: only data0 exists.
  function automatic logic [31:0] abstractcs_word(input logic busy, input cmderr_e err);
    logic [31:0] w;
    w        = '0;
    w[12]    = busy;
    w[10:8]  = err;
    w[3:0]   = 4'd1;
    return w;
  endfunction

endpackage

// File: rtl/kairo_dm_absreg.sv
// Abstract "Access Register" command engine: decodes DMI command writes, keeps
// data0/abstractcs and drives one register access into the hart per command.
module kairo_dm_absreg
  import kairo_dbg_pkg::*;
#(
  parameter int          AR_RD_LATENCY = 1,
  parameter logic [15:0] REGNO_LIMIT   = 16'h0FFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DMI_EN,
  input  logic        DMI_WR,
  input  logic [6:0]  DMI_AD,
  input  logic [31:0] DMI_DI,
  output logic [31:0] DMI_DO,
  input  logic        HALTED,
  output logic        AR_EN,
  output logic        AR_WR,
  output logic [15:0] AR_AD,
  output logic [31:0] AR_DI,
  input  logic [31:0] AR_DO
);

  localparam logic [1:0] LAT_LAST = 2'(AR_RD_LATENCY - 1);

  dm_state_e   state_q, state_d;
  cmderr_e     cmderr_q, cmderr_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] dmi_do_q, dmi_do_d;
  logic        ar_en_q, ar_en_d;
  logic        ar_wr_q, ar_wr_d;
  logic [15:0] ar_ad_q, ar_ad_d;
  logic [31:0] ar_di_q, ar_di_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        busy;
  logic        dmi_rd, dmi_wr;
  logic        busy_violation;
  logic        cmd_fmt_ok;
  logic [15:0] cmd_regno;
  logic        unused_cmd_bits;

  assign busy   = (state_q != ST_IDLE);
  assign dmi_rd = DMI_EN & ~DMI_WR;
  assign dmi_wr = DMI_EN & DMI_WR;

  assign cmd_regno  = DMI_DI[CMD_REGNO_LSB +: 16];
  assign cmd_fmt_ok = (DMI_DI[CMD_TYPE_LSB +: 8] == 8'd0) &&
                      (DMI_DI[CMD_AARSIZE_LSB +: 3] == AARSIZE_32) &&
                      !DMI_DI[CMD_POSTEXEC_BIT];
  assign unused_cmd_bits = DMI_DI[23] ^ DMI_DI[19];

  // Touching data0 or the command path while a command is in flight is a
  // sticky busy error; reads of abstractcs are always harmless.
  assign busy_violation = busy &&
    ((dmi_wr && (DMI_AD == DMI_DATA0 || DMI_AD == DMI_ABSTRACTCS || DMI_AD == DMI_COMMAND)) ||
     (dmi_rd && (DMI_AD == DMI_DATA0)));

  always_comb begin
    state_d  = state_q;
    cmderr_d = cmderr_q;
    data0_d  = data0_q;
    dmi_do_d = dmi_do_q;
    ar_en_d  = 1'b0;
    ar_wr_d  = ar_wr_q;
    ar_ad_d  = ar_ad_q;
    ar_di_d  = ar_di_q;
    cnt_d    = cnt_q;

    if (dmi_rd) begin
      case (DMI_AD)
        DMI_DATA0:      dmi_do_d = data0_q;
        DMI_ABSTRACTCS: dmi_do_d = abstractcs_word(busy, cmderr_q);
        default:        dmi_do_d = 32'd0;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (dmi_wr) begin
          case (DMI_AD)
            DMI_DATA0:      data0_d  = DMI_DI;
            DMI_ABSTRACTCS: cmderr_d = cmderr_e'(cmderr_q & ~DMI_DI[10:8]);
            DMI_COMMAND: begin
              if (cmderr_q == CMDERR_NONE) begin
                if (!cmd_fmt_ok) begin
                  cmderr_d = CMDERR_NOTSUP;
                end else if (!HALTED) begin
                  cmderr_d = CMDERR_HALTRESUME;
                end else if (!DMI_DI[CMD_TRANSFER_BIT]) begin
                  cmderr_d = CMDERR_NONE;
                end else if (cmd_regno > REGNO_LIMIT) begin
                  cmderr_d = CMDERR_EXCEPTION;
                end else begin
                  state_d = ST_ISSUE;
                  ar_en_d = 1'b1;
                  ar_wr_d = DMI_DI[CMD_WRITE_BIT];
                  ar_ad_d = cmd_regno;
                  ar_di_d = data0_q;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        cnt_d   = 2'd0;
        state_d = ar_wr_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          data0_d = AR_DO;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Evaluated last so an error set always overrides any clear above.
    if (busy_violation && cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cmderr_q <= CMDERR_NONE;
      data0_q  <= 32'd0;
      dmi_do_q <= 32'd0;
      ar_en_q  <= 1'b0;
      ar_wr_q  <= 1'b0;
      ar_ad_q  <= 16'd0;
      ar_di_q  <= 32'd0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      cmderr_q <= cmderr_d;
      data0_q  <= data0_d;
      dmi_do_q <= dmi_do_d;
      ar_en_q  <= ar_en_d;
      ar_wr_q  <= ar_wr_d;
      ar_ad_q  <= ar_ad_d;
      ar_di_q  <= ar_di_d;
      cnt_q    <= cnt_d;
    end
  end

  assign DMI_DO = dmi_do_q;
  assign AR_EN  = ar_en_q;
  assign AR_WR  = ar_wr_q;
  assign AR_AD  = ar_ad_q;
  assign AR_DI  = ar_di_q;

endmodule

// File: tb/tb_kairo_dm_absreg.sv
// Directed bench for kairo_dm_absreg: event-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_kairo_dm_absreg;

  localparam int L = 1;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        DMI_EN, DMI_WR;
  logic [6:0]  DMI_AD;
  logic [31:0] DMI_DI, DMI_DO;
  logic        HALTED;
  logic        AR_EN, AR_WR;
  logic [15:0] AR_AD;
  logic [31:0] AR_DI, AR_DO;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  kairo_dm_absreg #(.AR_RD_LATENCY(L), .REGNO_LIMIT(16'h0FFF)) dut (
    .CLK(CLK), .RST_N(RST_N), .DMI_EN(DMI_EN), .DMI_WR(DMI_WR), .DMI_AD(DMI_AD),
    .DMI_DI(DMI_DI), .DMI_DO(DMI_DO), .HALTED(HALTED), .AR_EN(AR_EN), .AR_WR(AR_WR),
    .AR_AD(AR_AD), .AR_DI(AR_DI), .AR_DO(AR_DO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] core_val(input logic [15:0] ad);
    return (ad == 16'h0301) ? 32'h4000_1104 : {16'hA5A5, ad};
  endfunction

  // Stub core: read data follows the presented address by L cycles.
  logic [31:0] pipe [L];
  always @(posedge CLK) begin
    pipe[0] <= core_val(AR_AD);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign AR_DO = pipe[L-1];

  // Event-level model: a busy countdown and a pending read value.
  logic [31:0] m_data0, m_dmi_do, m_ar_di, m_rd_val;
  logic [15:0] m_ar_ad;
  logic        m_ar_en, m_ar_wr, m_rd_pend;
  int          m_cmderr, m_busy_left;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_data0 = 0; m_dmi_do = 0; m_ar_di = 0; m_ar_ad = 0; m_ar_en = 0; m_ar_wr = 0;
      m_rd_pend = 0; m_rd_val = 0; m_cmderr = 0; m_busy_left = 0;
    end else begin
      automatic bit busy = (m_busy_left > 0);
      m_ar_en = 0;
      if (DMI_EN && !DMI_WR)
        m_dmi_do = (DMI_AD == 7'h04) ? m_data0 :
                   (DMI_AD == 7'h16) ? ((busy ? 32'h1000 : 32'h0) + (m_cmderr * 256) + 1) : 32'h0;
      if (busy) begin
        if (DMI_EN && m_cmderr == 0 &&
            (DMI_WR ? (DMI_AD == 7'h04 || DMI_AD == 7'h16 || DMI_AD == 7'h17) : DMI_AD == 7'h04))
          m_cmderr = 1;
        m_busy_left--;
        if (m_busy_left == 0 && m_rd_pend) begin
          m_data0 = m_rd_val;
          m_rd_pend = 0;
        end
      end else if (DMI_EN && DMI_WR) begin
        if (DMI_AD == 7'h04) m_data0 = DMI_DI;
        else if (DMI_AD == 7'h16) m_cmderr = m_cmderr & ~int'(DMI_DI[10:8]);
        else if (DMI_AD == 7'h17 && m_cmderr == 0) begin
          automatic int ctype = int'(DMI_DI >> 24);
          automatic int asz   = int'((DMI_DI >> 20) & 7);
          automatic int post  = int'((DMI_DI >> 18) & 1);
          automatic int xfer  = int'((DMI_DI >> 17) & 1);
          automatic int wr    = int'((DMI_DI >> 16) & 1);
          automatic int regno = int'(DMI_DI & 32'hFFFF);
          if (ctype != 0 || asz != 2 || post == 1) m_cmderr = 2;
          else if (!HALTED) m_cmderr = 4;
          else if (xfer == 0) ;
          else if (regno > 'h0FFF) m_cmderr = 3;
          else begin
            m_busy_left = (wr == 1) ? 1 : 1 + L;
            m_rd_pend = (wr == 0);
            m_rd_val  = core_val(16'(regno));
            m_ar_en = 1; m_ar_wr = (wr == 1); m_ar_ad = 16'(regno); m_ar_di = m_data0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("dmi_do", DMI_DO, m_dmi_do);
      chk("ar_en", 32'(AR_EN), 32'(m_ar_en));
      chk("ar_wr", 32'(AR_WR), 32'(m_ar_wr));
      chk("ar_ad", 32'(AR_AD), 32'(m_ar_ad));
      chk("ar_di", AR_DI, m_ar_di);
      if (AR_EN === 1'b1) pulses++;
    end
  end

  task automatic op(input logic en, input logic wr, input logic [6:0] ad, input logic [31:0] di);
    DMI_EN = en; DMI_WR = wr; DMI_AD = ad; DMI_DI = di;
    @(posedge CLK); #1;
    DMI_EN = 1'b0; DMI_WR = 1'b0;
  endtask
  task automatic wr_(input logic [6:0] ad, input logic [31:0] di); op(1'b1, 1'b1, ad, di); endtask
  task automatic rd_(input logic [6:0] ad); op(1'b1, 1'b0, ad, 32'd0); endtask
  task automatic idle_(input int n); for (int i = 0; i < n; i++) op(1'b0, 1'b0, 7'd0, 32'd0); endtask

  initial begin
    RST_N = 1'b0; DMI_EN = 1'b0; DMI_WR = 1'b0; DMI_AD = '0; DMI_DI = '0; HALTED = 1'b1;
    @(posedge CLK); #1; chk_en = 1'b1;
    idle_(2);
    chk("rst_dmi_do", DMI_DO, 32'h0);
    chk("rst_ar_en", 32'(AR_EN), 32'h0);
    chk("rst_ar_ad", 32'(AR_AD), 32'h0);
    RST_N = 1'b1;
    idle_(1);

    // register write
    wr_(7'h04, 32'h8000_0100);
    wr_(7'h17, 32'h0023_0305);
    chk("wr_ar_en", 32'(AR_EN), 32'h1);
    chk("wr_ar_wr", 32'(AR_WR), 32'h1);
    chk("wr_ar_ad", 32'(AR_AD), 32'h0305);
    chk("wr_ar_di", AR_DI, 32'h8000_0100);
    rd_(7'h16); chk("wr_busy1", DMI_DO, 32'h0000_1001);
    rd_(7'h16); chk("wr_busy0", DMI_DO, 32'h0000_0001);

    // register read
    wr_(7'h17, 32'h0022_0301);
    chk("rd_ar_en", 32'(AR_EN), 32'h1);
    chk("rd_ar_wr", 32'(AR_WR), 32'h0);
    rd_(7'h16); chk("rd_busy_a", DMI_DO, 32'h0000_1001);
    rd_(7'h16); chk("rd_busy_b", DMI_DO, 32'h0000_1001);
    rd_(7'h16); chk("rd_busy_c", DMI_DO, 32'h0000_0001);
    rd_(7'h04); chk("rd_data0", DMI_DO, 32'h4000_1104);

    // not halted, then sticky error until cleared
    HALTED = 1'b0;
    wr_(7'h17, 32'h0023_0305);
    rd_(7'h16); chk("halt_err", DMI_DO, 32'h0000_0401);
    HALTED = 1'b1;
    wr_(7'h17, 32'h0023_0305);
    idle_(2);
    rd_(7'h16); chk("halt_sticky", DMI_DO, 32'h0000_0401);
    wr_(7'h16, 32'h0000_0700);
    rd_(7'h16); chk("halt_clr", DMI_DO, 32'h0000_0001);

    // unsupported / exception / no-transfer / regno boundary
    wr_(7'h17, 32'h0032_0300);
    rd_(7'h16); chk("aarsize_err", DMI_DO, 32'h0000_0201);
    wr_(7'h16, 32'h0000_0700);
    wr_(7'h17, 32'h0022_1000);
    rd_(7'h16); chk("regno_err", DMI_DO, 32'h0000_0301);
    wr_(7'h16, 32'h0000_0700);
    wr_(7'h17, 32'h0020_1000);
    rd_(7'h16); chk("notransfer", DMI_DO, 32'h0000_0001);
    wr_(7'h17, 32'h0023_0FFF);
    chk("limit_ar_ad", 32'(AR_AD), 32'h0000_0FFF);
    idle_(1);

    // command accepted as soon as busy has dropped
    wr_(7'h17, 32'h0023_0010);
    idle_(1);
    wr_(7'h17, 32'h0023_0011);
    chk("b2b_ar_ad", 32'(AR_AD), 32'h0000_0011);
    idle_(1);

    // data0 write while a read is in flight
    wr_(7'h04, 32'h1111_2222);
    wr_(7'h17, 32'h0022_0301);
    wr_(7'h04, 32'hDEAD_BEEF);
    idle_(2);
    rd_(7'h04); chk("busywr_data0", DMI_DO, 32'h4000_1104);
    rd_(7'h16); chk("busywr_err", DMI_DO, 32'h0000_0101);
    wr_(7'h16, 32'h0000_0700);

    // data0 read while busy returns stale value
    wr_(7'h17, 32'h0022_0302);
    rd_(7'h04); chk("busyrd_stale", DMI_DO, 32'h4000_1104);
    idle_(1);
    rd_(7'h04); chk("busyrd_new", DMI_DO, 32'hA5A5_0302);
    rd_(7'h16); chk("busyrd_err", DMI_DO, 32'h0000_0101);
    wr_(7'h16, 32'h0000_0700);

    // reset during WAIT
    wr_(7'h17, 32'h0022_0301);
    idle_(1);
    RST_N = 1'b0;
    idle_(1);
    RST_N = 1'b1;
    chk("rstwait_ar_en", 32'(AR_EN), 32'h0);
    idle_(3);
    rd_(7'h04); chk("rstwait_data0", DMI_DO, 32'h0);
    rd_(7'h16); chk("rstwait_cs", DMI_DO, 32'h0000_0001);

    idle_(2);
    chk("ar_en_pulses", 32'(pulses), 32'd8);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
